// File: rtl/display_decimal_output_if.sv
// Bus between a value producer and the decimal display block:
// load handshake, converted BCD result and the multiplexed 7-segment drive.
interface display_decimal_output_if #(
  parameter int ANCHO = 12
);
  logic [ANCHO-1:0] valor_in;
  logic             cargar;
  logic             ocupado;
  logic             listo;
  logic [15:0]      bcd_out;
  logic [3:0]       an;
  logic [6:0]       seg;

  modport slave (
    input  valor_in, cargar,
    output ocupado, listo, bcd_out, an, seg
  );

  modport master (
    output valor_in, cargar,
    input  ocupado, listo, bcd_out, an, seg
  );
endinterface

// File: rtl/display_decimal_output.sv
// Binary-to-BCD (sequential double dabble) converter feeding a 4-digit
// time-multiplexed common-anode 7-segment display with leading-zero blanking.
module display_decimal_output #(
  parameter int ANCHO       = 12,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  display_decimal_output_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]       state_q, state_d;
  logic [ANCHO-1:0] shift_q, shift_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [3:0]       step_q, step_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic [15:0]      adjusted;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       seg_digit [4];
  logic             wrap;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction of every BCD nibble before the shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign adjusted[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                 ? scratch_q[4*gi +: 4] + 4'd3
                                 : scratch_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    step_d    = step_q;
    bcd_d     = bcd_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cargar) begin
          shift_d   = bus.valor_in;
          scratch_d = '0;
          step_d    = '0;
          ocupado_d = 1'b1;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        {scratch_d, shift_d} = {adjusted, shift_q} << 1;
        step_d = step_q + 4'd1;
        if (step_q == 4'(ANCHO - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d     = scratch_q;
        listo_d   = 1'b1;
        ocupado_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      bcd_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      bcd_q     <= bcd_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  // A digit above the units is blanked when it and every higher digit are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      if (gi == 0) begin : g_units
        assign seg_digit[gi] = dec7(bcd_q[3:0]);
      end else begin : g_upper
        assign seg_digit[gi] = (bcd_q[15:4*gi] == '0) ? 7'b1111111
                                                       : dec7(bcd_q[4*gi +: 4]);
      end
    end
  endgenerate

  always_comb begin
    wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_d);
    seg_d = seg_digit[idx_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.ocupado = ocupado_q;
  assign bus.listo   = listo_q;
  assign bus.bcd_out = bcd_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_display_decimal_output.sv
// Self-checking bench for display_decimal_output: decimal arithmetic reference
// for the BCD result and a cycle-count model of the display multiplexer.
module tb_display_decimal_output;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  display_decimal_output_if #(.ANCHO(12)) dut_if ();

  display_decimal_output #(.ANCHO(12), .REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges seen since reset release; the lit digit is (cyc/4) mod 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [15:0] ref_bcd(input int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 |
               ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Compare an/seg for n cycles against the displayed value v.
  task automatic check_display(input int v, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int idx;
      int p;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      idx = (cyc / 4) % 4;
      p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
      exp_an  = ~(4'b0001 << idx);
      exp_seg = (idx > 0 && v < p) ? 7'b1111111 : ref_seg((v / p) % 10);
      checks++;
      if (dut_if.an !== exp_an) begin
        errors++;
        $display("FAIL %s_an v=%0d cyc=%0d got=%b exp=%b", tag, v, cyc, dut_if.an, exp_an);
      end
      checks++;
      if (dut_if.seg !== exp_seg) begin
        errors++;
        $display("FAIL %s_seg v=%0d idx=%0d got=%b exp=%b", tag, v, idx, dut_if.seg, exp_seg);
      end
      tick(1);
    end
  endtask

  // Starts at a negedge; returns at the negedge right after the listo rise.
  task automatic do_load(input int v);
    logic [15:0] exp_bcd;
    exp_bcd = ref_bcd(v);
    dut_if.valor_in = 12'(v);
    dut_if.cargar   = 1'b1;
    tick(1);
    dut_if.cargar = 1'b0;
    for (int k = 0; k < 13; k++) begin
      checks++;
      if ({dut_if.ocupado, dut_if.listo} !== 2'b10) begin
        errors++;
        $display("FAIL load_busy v=%0d cycle=%0d got ocupado,listo=%b exp=10", v, k,
                 {dut_if.ocupado, dut_if.listo});
      end
      if (k < 12) tick(1);
    end
    tick(1);
    checks++;
    if ({dut_if.ocupado, dut_if.listo} !== 2'b01) begin
      errors++;
      $display("FAIL load_done v=%0d got ocupado,listo=%b exp=01", v,
               {dut_if.ocupado, dut_if.listo});
    end
    checks++;
    if (dut_if.bcd_out !== exp_bcd) begin
      errors++;
      $display("FAIL load_bcd v=%0d got=%h exp=%h", v, dut_if.bcd_out, exp_bcd);
    end
    $display("load valor_in=%0d bcd_out=%h expected=%h", v, dut_if.bcd_out, exp_bcd);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    dut_if.valor_in = '0;
    dut_if.cargar   = 1'b0;
    #20;
    checks++;
    if ({dut_if.ocupado, dut_if.listo, dut_if.bcd_out, dut_if.an, dut_if.seg} !==
        {1'b0, 1'b0, 16'h0000, 4'b1110, 7'b1000000}) begin
      errors++;
      $display("FAIL reset_state got=%b %b %h %b %b", dut_if.ocupado, dut_if.listo,
               dut_if.bcd_out, dut_if.an, dut_if.seg);
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({dut_if.ocupado, dut_if.listo, dut_if.bcd_out} !== 18'h0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got=%b %b %h", k, dut_if.ocupado,
                 dut_if.listo, dut_if.bcd_out);
      end
      check_display(0, 1, "reset");
    end
    $display("reset released, idle display checked");
  endtask

  task automatic test_value(input int v);
    do_load(v);
    tick(1);
    checks++;
    if (dut_if.listo !== 1'b0) begin
      errors++;
      $display("FAIL listo_width v=%0d got=%b exp=0", v, dut_if.listo);
    end
    tick(1);
    check_display(v, 16, "disp");
  endtask

  task automatic test_ignore_busy;
    int pulses;
    pulses = 0;
    dut_if.valor_in = 12'd12;
    dut_if.cargar   = 1'b1;
    tick(1);
    dut_if.cargar = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 4) begin
        dut_if.valor_in = 12'd999;
        dut_if.cargar   = 1'b1;
      end
      tick(1);
      if (i == 4) dut_if.cargar = 1'b0;
      if (dut_if.listo === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || dut_if.listo !== 1'b1) begin
      errors++;
      $display("FAIL ignore_listo got pulses=%0d listo=%b exp=1 1", pulses, dut_if.listo);
    end
    checks++;
    if (dut_if.bcd_out !== 16'h0012) begin
      errors++;
      $display("FAIL ignore_bcd got=%h exp=0012", dut_if.bcd_out);
    end
    $display("load 12 with ignored 999 bcd_out=%h", dut_if.bcd_out);
    test_value(1000);
  endtask

  task automatic test_reset_midconv;
    int pulses;
    pulses = 0;
    dut_if.valor_in = 12'd3998;
    dut_if.cargar   = 1'b1;
    tick(1);
    dut_if.cargar = 1'b0;
    tick(5);
    rst = 1'b0;
    #1;
    checks++;
    if ({dut_if.ocupado, dut_if.listo, dut_if.bcd_out, dut_if.an, dut_if.seg} !==
        {1'b0, 1'b0, 16'h0000, 4'b1110, 7'b1000000}) begin
      errors++;
      $display("FAIL midreset_clear got=%b %b %h %b %b", dut_if.ocupado, dut_if.listo,
               dut_if.bcd_out, dut_if.an, dut_if.seg);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (dut_if.listo === 1'b1) pulses++;
      tick(1);
    end
    checks++;
    if (pulses !== 0 || dut_if.bcd_out !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_nolisto got pulses=%0d bcd=%h exp=0 0000", pulses, dut_if.bcd_out);
    end
    $display("reset during conversion of 3998, bcd_out=%h", dut_if.bcd_out);
    test_value(7);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = int'($urandom_range(0, 4095));
      test_value(v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_value(46);
    test_value(4095);
    test_ignore_busy;
    test_reset_midconv;
    test_value(0);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
